// File: rtl/alu_compare_pipe_pkg.sv
// Shared opcode type, opcode constants and legality helper for the pipelined
// transfer/logic/compare unit.
package alu_pkg;

   typedef logic [3:0] op_t;

   localparam op_t OP_PASS = 4'd2;
   localparam op_t OP_INC  = 4'd3;
   localparam op_t OP_DEC  = 4'd4;
   localparam op_t OP_NOT  = 4'd5;
   localparam op_t OP_NOR  = 4'd6;
   localparam op_t OP_XOR  = 4'd7;
   localparam op_t OP_XNOR = 4'd8;
   localparam op_t OP_GT   = 4'd9;
   localparam op_t OP_LT   = 4'd10;
   localparam op_t OP_EQ   = 4'd11;

   function automatic logic is_legal_op(input op_t op);
      return (op >= OP_PASS) && (op <= OP_EQ);
   endfunction

endpackage

// File: rtl/alu_compare_pipe_if.sv
// Handshake bundle between the operand register file, the ALU pipe and the
// writeback mux: operand beat in, result beat out, plus the handoff counter.
interface alu_compare_pipe_if
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   op_t              ctrl;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] s;
   logic             ovf;
   logic             zero;
   logic             illegal;
   logic [CNT_W-1:0] op_count;

   modport master (
      output in_valid, a, b, ctrl, out_ready,
      input  in_ready, out_valid, s, ovf, zero, illegal, op_count
   );

   modport slave (
      input  in_valid, a, b, ctrl, out_ready,
      output in_ready, out_valid, s, ovf, zero, illegal, op_count
   );

endinterface

// File: rtl/alu_compare_pipe_core.sv
// Combinational result and flag logic of the ALU pipe. Build with ALU_SAT_EN
// defined to make INC/DEC saturate at MAX/MIN instead of wrapping.
module alu_compare_core
   import alu_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter bit SIGNED = 1'b0
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  op_t              i_ctrl,
   output logic [WIDTH-1:0] o_s,
   output logic             o_ovf,
   output logic             o_zero,
   output logic             o_illegal
);

   localparam logic [WIDTH-1:0] MAX_V = SIGNED ? {1'b0, {(WIDTH-1){1'b1}}} : {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] MIN_V = SIGNED ? {1'b1, {(WIDTH-1){1'b0}}} : {WIDTH{1'b0}};

   logic w_gt;
   logic w_lt;

   always_comb begin
      if (SIGNED) begin
         w_gt = $signed(i_a) > $signed(i_b);
         w_lt = $signed(i_a) < $signed(i_b);
      end else begin
         w_gt = i_a > i_b;
         w_lt = i_a < i_b;
      end
   end

   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      o_s       = '0;
      o_ovf     = 1'b0;
      o_illegal = !is_legal_op(i_ctrl);
      case (i_ctrl)
         OP_PASS: o_s = i_a;
         OP_INC: begin
            o_ovf = (i_a == MAX_V);
`ifdef ALU_SAT_EN
            o_s   = o_ovf ? i_a : i_a + WIDTH'(1);
`else
            o_s   = i_a + WIDTH'(1);
`endif
         end
         OP_DEC: begin
            o_ovf = (i_a == MIN_V);
`ifdef ALU_SAT_EN
            o_s   = o_ovf ? i_a : i_a - WIDTH'(1);
`else
            o_s   = i_a - WIDTH'(1);
`endif
         end
         OP_NOT:  o_s = ~i_a;
         OP_NOR:  o_s = ~(i_a | i_b);
         OP_XOR:  o_s = i_a ^ i_b;
         OP_XNOR: o_s = ~(i_a ^ i_b);
         OP_GT:   o_s = {{(WIDTH-1){1'b0}}, w_gt};
         OP_LT:   o_s = {{(WIDTH-1){1'b0}}, w_lt};
         OP_EQ:   o_s = {{(WIDTH-1){1'b0}}, (i_a == i_b)};
         default: o_s = '0;
      endcase
      o_zero = (o_s == '0);
   end

endmodule

// File: rtl/alu_compare_pipe.sv
// Two-stage valid/ready ALU pipe: S1 holds operands, S2 holds result and flags,
// plus a saturating handoff counter. ALU_SAT_EN selects saturating INC/DEC.
module alu_compare_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int SIGNED = 0,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   alu_compare_pipe_if.slave bus
);

   logic             r_s1_valid;
   logic             r_s2_valid;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   op_t              r_ctrl;
   logic [WIDTH-1:0] r_s;
   logic             r_ovf;
   logic             r_zero;
   logic             r_illegal;
   logic [CNT_W-1:0] r_op_count;

   logic             w_en1;
   logic             w_en2;
   logic [WIDTH-1:0] w_s;
   logic             w_ovf;
   logic             w_zero;
   logic             w_illegal;

   // Each stage advances when its downstream slot is empty or draining, so a
   // full pipe with out_ready high accepts and emits every cycle.
   assign w_en2 = !r_s2_valid || bus.out_ready;
   assign w_en1 = !r_s1_valid || w_en2;

   alu_compare_core #(
      .WIDTH  (WIDTH),
      .SIGNED (SIGNED != 0)
   ) u_core (
      .i_a       (r_a),
      .i_b       (r_b),
      .i_ctrl    (r_ctrl),
      .o_s       (w_s),
      .o_ovf     (w_ovf),
      .o_zero    (w_zero),
      .o_illegal (w_illegal)
   );

   // rst_n is expected to arrive already release-synchronised to clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s2_valid <= 1'b0;
         r_a        <= '0;
         r_b        <= '0;
         r_ctrl     <= '0;
         r_s        <= '0;
         r_ovf      <= 1'b0;
         r_zero     <= 1'b0;
         r_illegal  <= 1'b0;
         r_op_count <= '0;
      end else begin
         // NOTE: non-blocking updates let both stages shift on the same edge
         // without S2 seeing the operands S1 is loading this cycle.
         if (w_en1) begin
            r_s1_valid <= bus.in_valid;
            r_a        <= bus.a;
            r_b        <= bus.b;
            r_ctrl     <= bus.ctrl;
         end
         if (w_en2) begin
            r_s2_valid <= r_s1_valid;
            r_s        <= w_s;
            r_ovf      <= w_ovf;
            r_zero     <= w_zero;
            r_illegal  <= w_illegal;
         end
         if (r_s2_valid && bus.out_ready && (r_op_count != '1)) begin
            r_op_count <= r_op_count + CNT_W'(1);
         end
      end
   end

   assign bus.in_ready  = w_en1;
   assign bus.out_valid = r_s2_valid;
   assign bus.s         = r_s;
   assign bus.ovf       = r_ovf;
   assign bus.zero      = r_zero;
   assign bus.illegal   = r_illegal;
   assign bus.op_count  = r_op_count;

endmodule

// File: tb/tb_alu_compare_pipe.sv
// Self-checking bench: an unsigned 8-bit pipe driven through directed and random
// streams against a queue-based reference, plus a signed pipe with a 3-bit counter.
module tb_alu_compare_pipe;

   typedef struct {
      logic [7:0] s;
      logic       ovf;
      logic       zero;
      logic       illegal;
   } exp_t;

   logic clk;
   logic rst_n;

   int checks   = 0;
   int failures = 0;

   exp_t       q[$];
   int         cnt_u = 0;
   int         cnt_s = 0;
   bit         prev_stall = 0;
   logic [7:0] prev_s;
   logic [2:0] prev_flags;

   alu_compare_pipe_if #(.WIDTH(8), .CNT_W(16)) bus_u ();
   alu_compare_pipe_if #(.WIDTH(8), .CNT_W(3))  bus_s ();

   alu_compare_pipe #(.WIDTH(8), .SIGNED(0), .CNT_W(16)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_u)
   );

   alu_compare_pipe #(.WIDTH(8), .SIGNED(1), .CNT_W(3)) u_dut_s (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference result from the opcode table, using plain integer arithmetic.
   function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                  input logic [3:0] op, input bit sgn);
      exp_t e;
      int   ai, bi, maxv, minv, r;
      ai   = (sgn && a >= 8'd128) ? int'(a) - 256 : int'(a);
      bi   = (sgn && b >= 8'd128) ? int'(b) - 256 : int'(b);
      maxv = sgn ? 127 : 255;
      minv = sgn ? -128 : 0;
      e.ovf     = 1'b0;
      e.illegal = 1'b0;
      r         = 0;
      case (op)
         4'd2:  r = int'(a);
         4'd3: begin
            e.ovf = (ai == maxv);
            r     = int'(a) + 1;
`ifdef ALU_SAT_EN
            if (e.ovf) r = int'(a);
`endif
         end
         4'd4: begin
            e.ovf = (ai == minv);
            r     = int'(a) - 1;
`ifdef ALU_SAT_EN
            if (e.ovf) r = int'(a);
`endif
         end
         4'd5:  r = 255 - int'(a);
         4'd6:  r = 255 - int'(a | b);
         4'd7:  r = int'(a ^ b);
         4'd8:  r = 255 - int'(a ^ b);
         4'd9:  r = (ai > bi) ? 1 : 0;
         4'd10: r = (ai < bi) ? 1 : 0;
         4'd11: r = (a == b) ? 1 : 0;
         default: e.illegal = 1'b1;
      endcase
      e.s    = 8'(r & 255);
      e.zero = (e.s == 8'd0);
      return e;
   endfunction

   // One cycle on the unsigned pipe: inputs were set at the preceding negedge.
   task automatic tick(output bit acc);
      exp_t e;
      #1;
      acc = bus_u.in_valid && bus_u.in_ready;
      check("op_count", 32'(bus_u.op_count), 32'(cnt_u));
      if (prev_stall) begin
         check("hold_valid", 32'(bus_u.out_valid), 32'd1);
         check("hold_s", 32'(bus_u.s), 32'(prev_s));
         check("hold_flags", 32'({bus_u.ovf, bus_u.zero, bus_u.illegal}), 32'(prev_flags));
      end
      prev_stall = bus_u.out_valid && !bus_u.out_ready;
      prev_s     = bus_u.s;
      prev_flags = {bus_u.ovf, bus_u.zero, bus_u.illegal};
      if (bus_u.out_valid && bus_u.out_ready) begin
         if (q.size() == 0) begin
            check("unexpected_result", 32'(q.size()), 32'd1);
         end else begin
            e = q.pop_front();
            check("s", 32'(bus_u.s), 32'(e.s));
            check("ovf", 32'(bus_u.ovf), 32'(e.ovf));
            check("zero", 32'(bus_u.zero), 32'(e.zero));
            check("illegal", 32'(bus_u.illegal), 32'(e.illegal));
            cnt_u++;
         end
      end
      if (acc) q.push_back(model(bus_u.a, bus_u.b, bus_u.ctrl, 1'b0));
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain();
      bit acc;
      int n = 0;
      bus_u.in_valid  = 1'b0;
      bus_u.out_ready = 1'b1;
      while (q.size() != 0 && n < 20) begin
         tick(acc);
         n++;
      end
      check("drain_empty", 32'(q.size()), 32'd0);
   endtask

   task automatic send_u(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
      bit acc = 0;
      int n = 0;
      bus_u.in_valid = 1'b1;
      bus_u.a = a;
      bus_u.b = b;
      bus_u.ctrl = op;
      while (!acc && n < 20) begin
         tick(acc);
         n++;
      end
      check("send_accepted", 32'(acc), 32'd1);
      drain();
   endtask

   task automatic send_s(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
      exp_t e;
      int   n = 0;
      bus_s.in_valid = 1'b1;
      bus_s.a = a;
      bus_s.b = b;
      bus_s.ctrl = op;
      @(posedge clk);
      @(negedge clk);
      bus_s.in_valid = 1'b0;
      e = model(a, b, op, 1'b1);
      while (!bus_s.out_valid && n < 5) begin
         @(negedge clk);
         n++;
      end
      check("sgn_valid", 32'(bus_s.out_valid), 32'd1);
      check("sgn_s", 32'(bus_s.s), 32'(e.s));
      check("sgn_ovf", 32'(bus_s.ovf), 32'(e.ovf));
      check("sgn_illegal", 32'(bus_s.illegal), 32'(e.illegal));
      cnt_s++;
      @(negedge clk);
      check("sgn_op_count", 32'(bus_s.op_count), 32'((cnt_s > 7) ? 7 : cnt_s));
   endtask

   initial begin
      bit         acc;
      int         idx;
      int         n;
      logic [7:0] bp_a[5];

      rst_n = 1'b0;
      bus_u.in_valid = 1'b0; bus_u.a = '0; bus_u.b = '0; bus_u.ctrl = '0; bus_u.out_ready = 1'b1;
      bus_s.in_valid = 1'b0; bus_s.a = '0; bus_s.b = '0; bus_s.ctrl = '0; bus_s.out_ready = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_out_valid", 32'(bus_u.out_valid), 32'd0);
      check("rst_s", 32'(bus_u.s), 32'd0);
      check("rst_op_count", 32'(bus_u.op_count), 32'd0);
      check("rst_in_ready", 32'(bus_u.in_ready), 32'd1);

      // Latency: accepted in N, valid in N+2
      bus_u.in_valid = 1'b1; bus_u.a = 8'h5A; bus_u.b = 8'h0F; bus_u.ctrl = 4'd7;
      tick(acc);
      check("lat_accept", 32'(acc), 32'd1);
      bus_u.in_valid = 1'b0;
      check("lat_n1_valid", 32'(bus_u.out_valid), 32'd0);
      tick(acc);
      check("lat_n2_valid", 32'(bus_u.out_valid), 32'd1);
      check("lat_s", 32'(bus_u.s), 32'h55);
      check("lat_zero", 32'(bus_u.zero), 32'd0);
      tick(acc);
      check("lat_op_count", 32'(bus_u.op_count), 32'd1);

      // Overflow boundaries and neighbours
      send_u(8'hFF, 8'h00, 4'd3);
      send_u(8'hFE, 8'h00, 4'd3);
      send_u(8'h00, 8'h00, 4'd4);
      send_u(8'h01, 8'h00, 4'd4);
      send_u(8'h00, 8'h00, 4'd13);

      // Backpressure: 5 beats against a stalled output
      bp_a = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      bus_u.out_ready = 1'b0;
      idx = 0;
      bus_u.in_valid = 1'b1; bus_u.a = bp_a[0]; bus_u.b = 8'h0F; bus_u.ctrl = 4'd7;
      for (int c = 0; c < 4; c++) begin
         tick(acc);
         if (acc) begin
            idx++;
            bus_u.a = bp_a[idx];
         end
      end
      check("bp_accepted", 32'(idx), 32'd2);
      check("bp_in_ready", 32'(bus_u.in_ready), 32'd0);
      bus_u.out_ready = 1'b1;
      n = 0;
      while (idx < 5 && n < 20) begin
         tick(acc);
         if (acc) begin
            idx++;
            if (idx < 5) bus_u.a = bp_a[idx];
            else bus_u.in_valid = 1'b0;
         end
         n++;
      end
      check("bp_all_accepted", 32'(idx), 32'd5);
      drain();

      // Random stream with random backpressure
      for (int c = 0; c < 400; c++) begin
         bus_u.in_valid  = 1'($urandom_range(0, 1));
         bus_u.out_ready = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 5))
            0: bus_u.a = 8'hFF;
            1: bus_u.a = 8'h00;
            default: bus_u.a = 8'($urandom);
         endcase
         bus_u.b    = ($urandom_range(0, 3) == 0) ? bus_u.a : 8'($urandom);
         bus_u.ctrl = 4'($urandom_range(0, 15));
         tick(acc);
      end
      drain();
      check("rand_op_count", 32'(bus_u.op_count), 32'(cnt_u));

      // Signed pipe, also drives its 3-bit counter into saturation
      send_s(8'h80, 8'h01, 4'd9);
      send_s(8'h80, 8'h01, 4'd10);
      send_s(8'h80, 8'h01, 4'd13);
      send_s(8'h7F, 8'h00, 4'd3);
      send_s(8'h80, 8'h00, 4'd4);
      send_s(8'hFF, 8'h01, 4'd9);
      send_s(8'h01, 8'hFF, 4'd9);
      send_s(8'hFF, 8'hFF, 4'd11);
      send_s(8'h55, 8'hAA, 4'd6);

      // Mid-stream reset with two beats in flight
      bus_u.out_ready = 1'b0;
      bus_u.in_valid = 1'b1; bus_u.a = 8'h12; bus_u.b = 8'h34; bus_u.ctrl = 4'd2;
      tick(acc);
      bus_u.a = 8'h56;
      tick(acc);
      bus_u.in_valid = 1'b0;
      check("mid_valid_before", 32'(bus_u.out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_out_valid", 32'(bus_u.out_valid), 32'd0);
      check("mid_op_count", 32'(bus_u.op_count), 32'd0);
      q.delete();
      cnt_u = 0;
      prev_stall = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      bus_u.out_ready = 1'b1;
      @(negedge clk);
      check("post_rst_in_ready", 32'(bus_u.in_ready), 32'd1);
      check("post_rst_out_valid", 32'(bus_u.out_valid), 32'd0);
      send_u(8'h3C, 8'hC3, 4'd8);
      check("post_rst_op_count", 32'(bus_u.op_count), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
